// File: rtl/eu_wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: the writeback packet and the FIFO count-width helper.
package eu_pkg;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rob_id;
        logic [5:0]  dest;
        logic        wb_valid;
    } wb_packet_t;

    // Count must represent 0..depth inclusive, hence depth+1 states.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/eu_wb_arbiter_if.sv
// Writeback arbiter bus: fast/slow result inputs, register-file/ROB outputs, flush and status.
interface eu_wb_arbiter_if #(parameter int DEPTH = 4);

    logic        flush_i;
    logic        fast_valid_i;
    logic        fast_wb_valid_i;
    logic [31:0] fast_result_i;
    logic [4:0]  fast_rob_id_i;
    logic [5:0]  fast_dest_i;
    logic        slow_valid_i;
    logic        slow_ready_o;
    logic        slow_wb_valid_i;
    logic [31:0] slow_result_i;
    logic [4:0]  slow_rob_id_i;
    logic [5:0]  slow_dest_i;
    logic        issue_stall_o;
    logic        wen_o;
    logic [31:0] we_data_o;
    logic [5:0]  we_dest_o;
    logic        complete_o;
    logic [4:0]  rob_id_o;
    logic [eu_pkg::cnt_width(DEPTH)-1:0] fifo_count_o;

    modport slave (
        input  flush_i, fast_valid_i, fast_wb_valid_i, fast_result_i, fast_rob_id_i, fast_dest_i,
        input  slow_valid_i, slow_wb_valid_i, slow_result_i, slow_rob_id_i, slow_dest_i,
        output slow_ready_o, issue_stall_o, wen_o, we_data_o, we_dest_o, complete_o, rob_id_o,
        output fifo_count_o
    );

    modport master (
        output flush_i, fast_valid_i, fast_wb_valid_i, fast_result_i, fast_rob_id_i, fast_dest_i,
        output slow_valid_i, slow_wb_valid_i, slow_result_i, slow_rob_id_i, slow_dest_i,
        input  slow_ready_o, issue_stall_o, wen_o, we_data_o, we_dest_o, complete_o, rob_id_o,
        input  fifo_count_o
    );

endinterface

// File: rtl/eu_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of writeback packets; head read combinationally, 1-cycle push-to-visible.
// No internal backpressure: caller must not push when full or pop when empty; flush empties it.
module wb_fifo
    import eu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_vld,
    input  wb_packet_t                  push_dat,
    input  logic                        pop_vld,
    input  logic                        flush,
    output wb_packet_t                  head_dat,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);

    wb_packet_t     mem_q [DEPTH];
    wb_packet_t     mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_vld && !pop_vld) begin
                count_d = count_q + 1'b1;
            end else if (!push_vld && pop_vld) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);

endmodule

// File: rtl/eu_wb_arbiter.sv
// eu_wb_arbiter: shares one writeback port between fast (absolute priority) and FIFO-buffered slow results.
// Latency: fast 1 cycle, slow >= 2 cycles (1 with EU_WB_BYPASS_EN); slow_ready_o drops when full/flush, issue_stall_o throttles fast.
module eu_wb_arbiter
    import eu_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             cpu_clock_i,
    input  logic             cpu_reset_i,
    eu_wb_arbiter_if.slave   wb
);

    localparam int CW = cnt_width(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_packet_t     fast_pkt, slow_pkt, head_pkt, sel_pkt;
    logic           sel_vld;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           slow_accept, bypass, push_vld, pop_vld;

    logic           wen_q, wen_d;
    logic           complete_q, complete_d;
    logic [31:0]    data_q, data_d;
    logic [5:0]     dest_q, dest_d;
    logic [4:0]     rob_q, rob_d;
    logic [SW-1:0]  starve_q, starve_d;

    assign fast_pkt = '{result: wb.fast_result_i, rob_id: wb.fast_rob_id_i,
                        dest: wb.fast_dest_i, wb_valid: wb.fast_wb_valid_i};
    assign slow_pkt = '{result: wb.slow_result_i, rob_id: wb.slow_rob_id_i,
                        dest: wb.slow_dest_i, wb_valid: wb.slow_wb_valid_i};

    // Ready depends on the registered count only: a full FIFO refuses even while it pops.
    assign wb.slow_ready_o = !cpu_reset_i && !fifo_full && !wb.flush_i;
    assign slow_accept     = wb.slow_valid_i && wb.slow_ready_o;

`ifdef EU_WB_BYPASS_EN
    assign bypass = slow_accept && fifo_empty && !wb.fast_valid_i;
`else
    assign bypass = 1'b0;
`endif

    assign push_vld = slow_accept && !bypass;
    assign pop_vld  = !wb.flush_i && !wb.fast_valid_i && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (cpu_clock_i),
        .rst      (cpu_reset_i),
        .push_vld (push_vld),
        .push_dat (slow_pkt),
        .pop_vld  (pop_vld),
        .flush    (wb.flush_i),
        .head_dat (head_pkt),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        sel_vld = 1'b0;
        sel_pkt = fast_pkt;
        if (!wb.flush_i) begin
            if (wb.fast_valid_i) begin
                sel_vld = 1'b1;
            end else if (pop_vld) begin
                sel_vld = 1'b1;
                sel_pkt = head_pkt;
            end else if (bypass) begin
                sel_vld = 1'b1;
                sel_pkt = slow_pkt;
            end
        end
    end

    always_comb begin
        complete_d = sel_vld;
        wen_d      = sel_vld && sel_pkt.wb_valid;
        data_d     = sel_vld ? sel_pkt.result : data_q;
        dest_d     = sel_vld ? sel_pkt.dest   : dest_q;
        rob_d      = sel_vld ? sel_pkt.rob_id : rob_q;
    end

    // Counts cycles the current head has waited; cleared on empty, pop or flush.
    always_comb begin
        starve_d = starve_q;
        if (wb.flush_i || fifo_empty || pop_vld) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            wen_q      <= 1'b0;
            complete_q <= 1'b0;
            data_q     <= '0;
            dest_q     <= '0;
            rob_q      <= '0;
            starve_q   <= '0;
        end else begin
            wen_q      <= wen_d;
            complete_q <= complete_d;
            data_q     <= data_d;
            dest_q     <= dest_d;
            rob_q      <= rob_d;
            starve_q   <= starve_d;
        end
    end

    assign wb.wen_o         = wen_q;
    assign wb.complete_o    = complete_q;
    assign wb.we_data_o     = data_q;
    assign wb.we_dest_o     = dest_q;
    assign wb.rob_id_o      = rob_q;
    assign wb.issue_stall_o = (starve_q == SW'(STARVE_LIMIT));
    assign wb.fifo_count_o  = fifo_count;

endmodule
